// File: rtl/uart_pkg.sv
// Shared constants for the UART receive-side framing path: header defaults,
// error cause codes and parser state encoding.
package uart_pkg;

  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    HUNT_H0 = 3'd0,
    HUNT_H1 = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4
  } parse_state_e;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte silence timer: counts clocks while enabled and not cleared,
// and emits a one-cycle registered pulse when the count reaches LIMIT.
module uart_byte_timer #(
  parameter int unsigned LIMIT = 1000
) (
  input  logic i_clk_sys,
  input  logic i_rst_n,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam logic [31:0] LAST = 32'(LIMIT - 1);

  logic [31:0] count_q;

  // The pulse rises on the clock where the count would become LIMIT.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      expire_o <= 1'b0;
    end else begin
      expire_o <= 1'b0;
      if (clear_i || !enable_i) begin
        count_q <= '0;
      end else if (count_q == LAST) begin
        count_q  <= '0;
        expire_o <= 1'b1;
      end else begin
        count_q <= count_q + 32'd1;
      end
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Header-hunting, length-prefixed frame collector with 8-bit additive checksum
// and inter-byte timeout, fed by the UART receiver byte/done stream.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE       = 50,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter logic [7:0]  HDR0          = HDR0_DEF,
  parameter logic [7:0]  HDR1          = HDR1_DEF,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic                 i_clk_sys,
  input  logic                 i_rst_n,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  output logic [8*MAX_LEN-1:0] o_frame_data,
  output logic [7:0]           o_frame_len,
  output logic                 o_frame_valid,
  output logic                 o_frame_err,
  output logic [1:0]           o_err_code
);

  // Evaluated in 64 bits so large clock/baud ratios cannot overflow.
  localparam longint unsigned TO_CLKS_L = 64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLK_FRE)
                                          * 64'd1000000 / 64'(BAUD_RATE);
  localparam int unsigned     TO_CLKS   = 32'(TO_CLKS_L);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  parse_state_e         state_q;
  logic                 rx_done_q;
  logic [7:0]           len_q;
  logic [7:0]           sum_q;
  logic [7:0]           idx_q;
  logic [8*MAX_LEN-1:0] buf_q;
  logic                 byte_evt;
  logic                 expire;

  assign byte_evt = i_rx_done & ~rx_done_q;

  uart_byte_timer #(
    .LIMIT (TO_CLKS)
  ) u_timer (
    .i_clk_sys (i_clk_sys),
    .i_rst_n   (i_rst_n),
    .enable_i  (state_q != HUNT_H0),
    .clear_i   (byte_evt),
    .expire_o  (expire)
  );

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= HUNT_H0;
      rx_done_q     <= 1'b0;
      len_q         <= '0;
      sum_q         <= '0;
      idx_q         <= '0;
      buf_q         <= '0;
      o_frame_data  <= '0;
      o_frame_len   <= '0;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      o_err_code    <= ERR_NONE;
    end else begin
      rx_done_q     <= i_rx_done;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      // A byte event takes priority over a coincident timeout.
      if (byte_evt) begin
        unique case (state_q)
          HUNT_H0: begin
            if (i_rx_data == HDR0) state_q <= HUNT_H1;
          end
          HUNT_H1: begin
            if (i_rx_data == HDR1)      state_q <= LEN;
            else if (i_rx_data != HDR0) state_q <= HUNT_H0;
          end
          LEN: begin
            len_q <= i_rx_data;
            sum_q <= i_rx_data;
            idx_q <= '0;
            buf_q <= '0;
            if (i_rx_data > MAX_LEN_B) begin
              o_frame_err <= 1'b1;
              o_err_code  <= ERR_LEN;
              state_q     <= HUNT_H0;
            end else if (i_rx_data == 8'd0) begin
              state_q <= CHECK;
            end else begin
              state_q <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
              if (idx_q == 8'(i)) buf_q[8*i +: 8] <= i_rx_data;
            end
            sum_q <= sum_q + i_rx_data;
            idx_q <= idx_q + 8'd1;
            if ((idx_q + 8'd1) == len_q) state_q <= CHECK;
          end
          CHECK: begin
            if (i_rx_data == sum_q) begin
              o_frame_data  <= buf_q;
              o_frame_len   <= len_q;
              o_frame_valid <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
              o_err_code  <= ERR_CSUM;
            end
            state_q <= HUNT_H0;
          end
          default: state_q <= HUNT_H0;
        endcase
      end else if (expire && (state_q != HUNT_H0)) begin
        o_frame_err <= 1'b1;
        o_err_code  <= ERR_TIMEOUT;
        state_q     <= HUNT_H0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected frame/error events are
// queued as bytes are driven and matched against each output pulse.
module tb_uart_frame_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned LIMIT   = 4 * 10 * 1 * 1000000 / 100000;

  typedef struct {
    bit           err;
    logic [1:0]   code;
    logic [7:0]   len;
    logic [127:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [7:0]           i_rx_data = '0;
  logic                 i_rx_done = 1'b0;
  logic [8*MAX_LEN-1:0] o_frame_data;
  logic [7:0]           o_frame_len;
  logic                 o_frame_valid;
  logic                 o_frame_err;
  logic [1:0]           o_err_code;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   evt_cyc  = 0;
  exp_t sb[$];
  exp_t e;
  logic [1:0]   m_code = '0;
  logic [7:0]   m_len  = '0;
  logic [127:0] m_data = '0;

  uart_frame_parser #(
    .CLK_FRE       (1),
    .BAUD_RATE     (100000),
    .HDR0          (8'hAA),
    .HDR1          (8'h55),
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_BYTES (4)
  ) dut (
    .i_clk_sys     (clk),
    .i_rst_n       (rst_n),
    .i_rx_data     (i_rx_data),
    .i_rx_done     (i_rx_done),
    .o_frame_data  (o_frame_data),
    .o_frame_len   (o_frame_len),
    .o_frame_valid (o_frame_valid),
    .o_frame_err   (o_frame_err),
    .o_err_code    (o_err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (o_frame_valid || o_frame_err)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b code=%0d, none expected",
                 o_frame_valid, o_frame_err, o_err_code);
      end else begin
        e = sb.pop_front();
        if (o_frame_valid !== !e.err || o_frame_err !== e.err) begin
          n_fail++;
          $display("FAIL pulse_kind: valid=%0b err=%0b, expected err=%0b",
                   o_frame_valid, o_frame_err, e.err);
        end
        n_checks++;
        if (o_err_code !== e.code) begin
          n_fail++;
          $display("FAIL err_code: got %0d expected %0d", o_err_code, e.code);
        end
        n_checks++;
        if (o_frame_len !== e.len) begin
          n_fail++;
          $display("FAIL frame_len: got %0d expected %0d", o_frame_len, e.len);
        end
        n_checks++;
        if (o_frame_data !== e.data) begin
          n_fail++;
          $display("FAIL frame_data: got %h expected %h", o_frame_data, e.data);
        end
      end
    end
  end

  function automatic logic [127:0] pack(input logic [7:0] b[$]);
    logic [127:0] v = '0;
    for (int i = 0; i < b.size(); i++) v[8*i +: 8] = b[i];
    return v;
  endfunction

  task automatic push_good(input logic [7:0] len, input logic [7:0] pl[$]);
    exp_t x;
    m_len  = len;
    m_data = pack(pl);
    x.err = 1'b0; x.code = m_code; x.len = m_len; x.data = m_data;
    sb.push_back(x);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t x;
    m_code = code;
    x.err = 1'b1; x.code = m_code; x.len = m_len; x.data = m_data;
    sb.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge clk);
    #1 evt_cyc = cyc;
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] b[$], input int hold);
    for (int i = 0; i < b.size(); i++) send_byte(b[i], hold);
  endtask

  task automatic drain(input string name);
    repeat (20) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected pulses never seen", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if (o_frame_data !== '0 || o_frame_len !== 8'd0 || o_frame_valid !== 1'b0 ||
        o_frame_err !== 1'b0 || o_err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: data=%h len=%0d valid=%0b err=%0b code=%0d, expected all 0",
               name, o_frame_data, o_frame_len, o_frame_valid, o_frame_err, o_err_code);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset_values");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("after_reset_release");
  endtask

  task automatic test_good_frame();
    push_good(8'd3, '{8'h11, 8'h22, 8'h33});
    send_seq('{8'hAA, 8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 1);
    drain("good_frame");
  endtask

  task automatic test_bad_checksum();
    push_err(2'd1);
    send_seq('{8'hAA, 8'h55, 8'h02, 8'h01, 8'h02, 8'h00}, 1);
    drain("bad_checksum");
  endtask

  task automatic test_empty_and_oversize();
    push_good(8'd0, '{});
    send_seq('{8'hAA, 8'h55, 8'h00, 8'h00}, 1);
    push_err(2'd2);
    send_seq('{8'hAA, 8'h55, 8'h11}, 1);
    push_good(8'd1, '{8'h05});
    send_seq('{8'hAA, 8'h55, 8'h01, 8'h05, 8'h06}, 1);
    drain("empty_oversize");
  endtask

  task automatic test_resync();
    push_good(8'd1, '{8'h7E});
    send_seq('{8'h00, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'h7E, 8'h7F}, 1);
    drain("resync");
  endtask

  task automatic test_back_to_back();
    push_good(8'd2, '{8'h10, 8'h20});
    push_good(8'd1, '{8'hFF});
    push_good(8'd16, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                       8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10});
    send_seq('{8'hAA, 8'h55, 8'h02, 8'h10, 8'h20, 8'h32,
               8'hAA, 8'h55, 8'h01, 8'hFF, 8'h00,
               8'hAA, 8'h55, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
               8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
               8'h10, 8'h98}, 1);
    drain("back_to_back");
  endtask

  task automatic test_timeout();
    int last;
    int seen_at = -1;
    push_err(2'd3);
    send_seq('{8'hAA, 8'h55, 8'h02, 8'h01}, 1);
    last = evt_cyc;
    for (int k = 0; k < int'(LIMIT) + 20 && seen_at < 0; k++) begin
      @(negedge clk);
      if (o_frame_err) seen_at = cyc;
    end
    n_checks++;
    if (seen_at - last != int'(LIMIT) + 1) begin
      n_fail++;
      $display("FAIL timeout_latency: err after %0d clocks, expected %0d",
               seen_at - last, LIMIT + 1);
    end
    drain("timeout");
    push_good(8'd1, '{8'h42});
    send_seq('{8'hAA, 8'h55, 8'h01, 8'h42, 8'h43}, 1);
    drain("after_timeout");
  endtask

  task automatic test_timeout_race();
    int last;
    push_good(8'd2, '{8'h01, 8'h02});
    send_seq('{8'hAA, 8'h55, 8'h02, 8'h01}, 1);
    last = evt_cyc;
    while (cyc != last + int'(LIMIT)) @(negedge clk);
    i_rx_data = 8'h02;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
    send_byte(8'h05, 1);
    drain("timeout_race");
  endtask

  task automatic test_reset_midframe();
    send_seq('{8'hAA, 8'h55, 8'h02}, 1);
    @(negedge clk);
    rst_n = 1'b0;
    m_code = '0; m_len = '0; m_data = '0;
    @(negedge clk);
    check_all_zero("reset_midframe");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_no_pulse");
    push_good(8'd1, '{8'h09});
    send_seq('{8'hAA, 8'h55, 8'h01, 8'h09, 8'h0A}, 1);
    drain("after_reset");
  endtask

  task automatic test_held_strobe();
    push_good(8'd3, '{8'h11, 8'h22, 8'h33});
    send_seq('{8'hAA, 8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 3);
    push_err(2'd1);
    send_seq('{8'hAA, 8'h55, 8'h01, 8'h11, 8'h11}, 3);
    drain("held_strobe");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_empty_and_oversize();
    test_resync();
    test_back_to_back();
    test_timeout();
    test_timeout_race();
    test_reset_midframe();
    test_held_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
